// File: rtl/core_pkg.sv
// Shared definitions for the core's pipeline hazard control.
//   REG_AW          : register-index width
//   FWD_RF/MEM/WB   : EX operand forwarding select encodings
//   state_e         : hazard controller state (RUN, FREEZE)
package core_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN,
        FREEZE
    } state_e;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one EX-stage source operand.
//   ex_rs        : source register of the EX instruction
//   mem_rd/we    : MEM-stage destination and write enable
//   mem_is_load  : MEM-stage instruction is a load (data not yet available)
//   wb_rd/we     : WB-stage destination and write enable
//   fwd_sel      : FWD_RF, FWD_MEM or FWD_WB
module fwd_unit
    import core_pkg::*;
#(
    parameter int unsigned AW = REG_AW
) (
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_we,
    input  logic          mem_is_load,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_we,
    output logic [1:0]    fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired to zero and must never be forwarded.
    assign mem_hit = mem_we && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_we && (wb_rd != '0) && (wb_rd == ex_rs);

    // MEM is the younger producer and takes priority over WB.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
//   id_*            : ID-stage source registers and read enables
//   ex_*            : EX-stage sources, destination, write/load flags
//   mem_*, wb_*     : later-stage destinations for forwarding
//   ex_redirect     : taken branch/jump resolved in EX
//   dmem_busy       : data memory not ready, freezes the whole pipeline
//   forward_a/b     : EX operand forwarding selects
//   *_stall         : hold PC / IF/ID / ID/EX / EX/MEM
//   ifid/idex_flush : load a bubble
//   err_timeout     : sticky watchdog error after WAIT_MAX busy cycles
//   cnt_stall/flush : stall-cycle and redirect-flush performance counters
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic              ex_redirect,
    input  logic              dmem_busy,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              exmem_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush
);

    import core_pkg::state_e;
    import core_pkg::RUN;
    import core_pkg::FREEZE;

    localparam int unsigned WW = $clog2(WAIT_MAX + 1);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
    logic             load_use;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_unit #(
        .AW (REG_AW)
    ) u_fwd_a (
        .ex_rs       (ex_rs1),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .fwd_sel     (forward_a)
    );

    fwd_unit #(
        .AW (REG_AW)
    ) u_fwd_b (
        .ex_rs       (ex_rs2),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .fwd_sel     (forward_b)
    );

    // ------------------------------------------------------------------
    // Hazard detection and pipeline control
    // ------------------------------------------------------------------
    assign load_use = ex_is_load && ex_we && (ex_rd != '0) &&
                      ((id_re1 && (id_rs1 == ex_rd)) || (id_re2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (dmem_busy)  state_d = FREEZE;
            FREEZE:  if (!dmem_busy) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Freeze wins over everything; once memory is ready again the pending
    // redirect or load-use is handled in that same cycle, even though the
    // state register still reads FREEZE until the following edge.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (dmem_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is killed, so a load-use on it is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog and performance counters
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = '0;
        if (dmem_busy) begin
            wait_cnt_d = (wait_cnt_q == WW'(WAIT_MAX)) ? wait_cnt_q : wait_cnt_q + WW'(1);
        end
        err_d       = err_q || (dmem_busy && (wait_cnt_d == WW'(WAIT_MAX)));
        cnt_stall_d = cnt_stall_q + CNT_W'(pc_stall);
        // Only a redirect drives ifid_flush, so it marks redirect flushes.
        cnt_flush_d = cnt_flush_q + CNT_W'(ifid_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign err_timeout = err_q;
    assign cnt_stall   = cnt_stall_q;
    assign cnt_flush   = cnt_flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned WM = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_re1, id_re2, ex_we, ex_is_load, mem_we, mem_is_load, wb_we;
    logic          ex_redirect, dmem_busy;
    logic [1:0]    forward_a, forward_b;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
    logic          err_timeout;
    logic [CW-1:0] cnt_stall, cnt_flush;

    hazard_ctrl #(
        .REG_AW   (AW),
        .CNT_W    (CW),
        .WAIT_MAX (WM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_re1      (id_re1),
        .id_re2      (id_re2),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .ex_redirect (ex_redirect),
        .dmem_busy   (dmem_busy),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .idex_stall  (idex_stall),
        .exmem_stall (exmem_stall),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .err_timeout (err_timeout),
        .cnt_stall   (cnt_stall),
        .cnt_flush   (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state
    int unsigned m_busy_run;
    int unsigned m_cnt_stall;
    int unsigned m_cnt_flush;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (mem_we && !mem_is_load && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_we && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_re1, id_re2, ex_we, ex_is_load, mem_we, mem_is_load, wb_we} = '0;
        ex_redirect = 1'b0;
        dmem_busy   = 1'b0;
    endtask

    task automatic model_reset();
        m_busy_run  = 0;
        m_cnt_stall = 0;
        m_cnt_flush = 0;
        m_err       = 1'b0;
    endtask

    // Called just after a rising edge; checks the cycle, then advances the model.
    task automatic cycle();
        bit   lu;
        bit   e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf;
        logic [5:0] got_ctl, exp_ctl;
        @(negedge clk);
        lu = ex_is_load && ex_we && ex_rd != 0 &&
             ((id_re1 && id_rs1 == ex_rd) || (id_re2 && id_rs2 == ex_rd));
        {e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf} = '0;
        if (dmem_busy) {e_pc, e_ifs, e_ids, e_exs} = 4'b1111;
        else if (ex_redirect) {e_iff, e_idf} = 2'b11;
        else if (lu) {e_pc, e_ifs, e_idf} = 3'b111;
        got_ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
        exp_ctl = {e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf};
        chk("forward_a", 32'(forward_a), 32'(ref_fwd(ex_rs1)));
        chk("forward_b", 32'(forward_b), 32'(ref_fwd(ex_rs2)));
        chk("stall_flush_ctl", 32'(got_ctl), 32'(exp_ctl));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("cnt_stall", cnt_stall, m_cnt_stall);
        chk("cnt_flush", cnt_flush, m_cnt_flush);
        @(posedge clk);
        if (dmem_busy) begin
            m_busy_run++;
            if (m_busy_run >= WM) m_err = 1'b1;
        end else begin
            m_busy_run = 0;
        end
        if (e_pc) m_cnt_stall++;
        if (e_iff) m_cnt_flush++;
        #1;
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt_stall", cnt_stall, 32'd0);
        chk("rst_cnt_flush", cnt_flush, 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt_stall", cnt_stall, 32'd0);
        chk("reset_cnt_flush", cnt_flush, 32'd0);
        chk("reset_err", 32'(err_timeout), 32'd0);
        chk("reset_ctl", 32'({pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
                              idex_flush}), 32'd0);
        rst_n = 1'b1;

        // Forwarding priority
        ex_rs1 = 5; mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1;
        #1 chk("fwd_mem_prio", 32'(forward_a), 32'd1);
        mem_we = 0;
        #1 chk("fwd_wb", 32'(forward_a), 32'd2);
        ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_we = 1;
        #1 chk("fwd_x0", 32'(forward_a), 32'd0);
        // MEM load is not forwarded
        clear_inputs();
        mem_is_load = 1; mem_we = 1; mem_rd = 7; ex_rs2 = 7;
        #1 chk("fwd_mem_load", 32'(forward_b), 32'd0);
        wb_rd = 7; wb_we = 1;
        #1 chk("fwd_mem_load_wb", 32'(forward_b), 32'd2);
        cycle();

        // Load-use, then same with the read disabled
        clear_inputs();
        ex_is_load = 1; ex_we = 1; ex_rd = 3; id_rs2 = 3; id_re2 = 1;
        #1 chk("lu_pc_stall", 32'(pc_stall), 32'd1);
        cycle();
        chk("lu_cnt_stall", cnt_stall, 32'd1);
        id_re2 = 0;
        cycle();

        // Redirect beats load-use
        id_re2 = 1; ex_redirect = 1;
        #1 chk("redir_pc_stall", 32'(pc_stall), 32'd0);
        cycle();
        chk("redir_cnt_flush", cnt_flush, 32'd1);

        // Memory freeze with a pending redirect
        clear_inputs();
        ex_redirect = 1; dmem_busy = 1;
        repeat (3) cycle();
        dmem_busy = 0;
        #1 chk("post_freeze_flush", 32'(ifid_flush), 32'd1);
        cycle();
        clear_inputs();
        cycle();
        chk("freeze_cnt_stall", cnt_stall, 32'd4);
        chk("freeze_cnt_flush", cnt_flush, 32'd2);
        chk("freeze_no_err", 32'(err_timeout), 32'd0);

        // Watchdog
        dmem_busy = 1;
        repeat (6) cycle();
        dmem_busy = 0;
        repeat (2) cycle();
        chk("wdog_sticky", 32'(err_timeout), 32'd1);

        // Reset in the middle of a freeze
        dmem_busy = 1;
        repeat (2) cycle();
        do_reset();
        dmem_busy = 0;
        cycle();

        // Randomized traffic with a small register space to force matches
        for (int i = 0; i < 400; i++) begin
            id_rs1      = AW'($urandom_range(0, 3));
            id_rs2      = AW'($urandom_range(0, 3));
            ex_rs1      = AW'($urandom_range(0, 3));
            ex_rs2      = AW'($urandom_range(0, 3));
            ex_rd       = AW'($urandom_range(0, 3));
            mem_rd      = AW'($urandom_range(0, 3));
            wb_rd       = AW'($urandom_range(0, 3));
            id_re1      = 1'($urandom);
            id_re2      = 1'($urandom);
            ex_we       = 1'($urandom);
            ex_is_load  = 1'($urandom);
            mem_we      = 1'($urandom);
            mem_is_load = 1'($urandom);
            wb_we       = 1'($urandom);
            ex_redirect = ($urandom_range(0, 3) == 0);
            // Sticky busy to produce runs around the watchdog limit
            dmem_busy   = dmem_busy ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
            if (i == 200) do_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
